// File: rtl/demux_scatter_sequencer_if.sv
// Handshake and drive bundle between a scatter requester and the sequencer.
// The slave side is the sequencer; the master side is whoever issues transfers.
interface demux_scatter_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] data;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       dout;
    logic       strobe;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, data, mask,
        input  sel, dout, strobe, busy, done
    );

    modport slave (
        input  start, abort, data, mask,
        output sel, dout, strobe, busy, done
    );
endinterface

// File: rtl/demux_scatter_sequencer.sv
// Scatters the bits of a captured word onto a 1-to-8 demux, visiting masked channels
// in ascending order, holding each for HOLD cycles, then pulsing done.
module demux_scatter_sequencer #(
    parameter int unsigned HOLD = 1
) (
    input logic                        clk_i,
    input logic                        rst_i,
    demux_scatter_sequencer_if.slave   bus_io
);
    localparam int unsigned CntW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {StIdle, StDrive, StFin} state_e;

    state_e            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        pend_q, pend_d;
    logic [CntW-1:0]   hcnt_q, hcnt_d;
    logic [2:0]        sel_q, sel_d;
    logic              dout_q, dout_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pend_d  = pend_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    data_d  = bus_io.data;
                    pend_d  = bus_io.mask;
                    hcnt_d  = '0;
                    state_d = (bus_io.mask != 8'd0) ? StDrive : StFin;
                end
            end
            StDrive: begin
                // Abort wins over hold completion and the move to FIN.
                if (bus_io.abort) begin
                    state_d = StIdle;
                    pend_d  = '0;
                    hcnt_d  = '0;
                end else if (hcnt_q == CntW'(HOLD - 1)) begin
                    pend_d = pend_q & ~(8'd1 << lowest_idx(pend_q));
                    hcnt_d = '0;
                    if (pend_d == 8'd0) state_d = StFin;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of what the next state will present.
        strobe_d = (state_d == StDrive);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StFin);
        sel_d    = strobe_d ? lowest_idx(pend_d) : 3'd0;
        dout_d   = strobe_d ? data_d[sel_d] : 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            data_q   <= '0;
            pend_q   <= '0;
            hcnt_q   <= '0;
            sel_q    <= '0;
            dout_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            hcnt_q   <= hcnt_d;
            sel_q    <= sel_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus_io.sel    = sel_q;
    assign bus_io.dout   = dout_q;
    assign bus_io.strobe = strobe_q;
    assign bus_io.busy   = busy_q;
    assign bus_io.done   = done_q;
endmodule

// File: tb/tb_demux_scatter_sequencer.sv
// Drives three sequencers (HOLD=1,2,3) with shared stimulus and compares each cycle
// against a queue-of-expected-drives model built from the channel mask.
module tb_demux_scatter_sequencer;
    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] data;
    logic [7:0] mask;

    typedef struct packed {
        logic [2:0] sel;
        logic       dout;
        logic       strobe;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t cur [3];
    obs_t q_exp [3][$];
    int   n_cmp;
    int   n_bad;

    demux_scatter_sequencer_if bus1 ();
    demux_scatter_sequencer_if bus2 ();
    demux_scatter_sequencer_if bus3 ();

    assign bus1.start = start;
    assign bus1.abort = abort;
    assign bus1.data  = data;
    assign bus1.mask  = mask;
    assign bus2.start = start;
    assign bus2.abort = abort;
    assign bus2.data  = data;
    assign bus2.mask  = mask;
    assign bus3.start = start;
    assign bus3.abort = abort;
    assign bus3.data  = data;
    assign bus3.mask  = mask;

    demux_scatter_sequencer #(.HOLD(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus_io(bus1));
    demux_scatter_sequencer #(.HOLD(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus_io(bus2));
    demux_scatter_sequencer #(.HOLD(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .bus_io(bus3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic obs_t get_obs(input int h);
        obs_t o;
        case (h)
            0:       begin o.sel = bus1.sel; o.dout = bus1.dout; o.strobe = bus1.strobe;
                           o.busy = bus1.busy; o.done = bus1.done; end
            1:       begin o.sel = bus2.sel; o.dout = bus2.dout; o.strobe = bus2.strobe;
                           o.busy = bus2.busy; o.done = bus2.done; end
            default: begin o.sel = bus3.sel; o.dout = bus3.dout; o.strobe = bus3.strobe;
                           o.busy = bus3.busy; o.done = bus3.done; end
        endcase
        return o;
    endfunction

    task automatic compare_all(input string what);
        obs_t o;
        for (int h = 0; h < 3; h++) begin
            o = get_obs(h);
            check($sformatf("%s.h%0d.sel", what, h + 1), 32'(o.sel), 32'(cur[h].sel));
            check($sformatf("%s.h%0d.in", what, h + 1), 32'(o.dout), 32'(cur[h].dout));
            check($sformatf("%s.h%0d.strobe", what, h + 1), 32'(o.strobe), 32'(cur[h].strobe));
            check($sformatf("%s.h%0d.busy", what, h + 1), 32'(o.busy), 32'(cur[h].busy));
            check($sformatf("%s.h%0d.done", what, h + 1), 32'(o.done), 32'(cur[h].done));
        end
    endtask

    task automatic model_clear();
        for (int h = 0; h < 3; h++) begin
            q_exp[h].delete();
            cur[h] = '0;
        end
    endtask

    // Whole transfer is expanded into its per-cycle output list when START is accepted.
    task automatic model_step(input int h);
        obs_t e;
        if (!cur[h].busy) begin
            if (start) begin
                q_exp[h].delete();
                for (int c = 0; c < 8; c++) begin
                    if (mask[c]) begin
                        for (int r = 0; r <= h; r++) begin
                            e = '0;
                            e.sel = 3'(c);
                            e.dout = data[c];
                            e.strobe = 1'b1;
                            e.busy = 1'b1;
                            q_exp[h].push_back(e);
                        end
                    end
                end
                e = '0;
                e.busy = 1'b1;
                e.done = 1'b1;
                q_exp[h].push_back(e);
            end
        end else if (cur[h].strobe && abort) begin
            q_exp[h].delete();
        end
        cur[h] = (q_exp[h].size() != 0) ? q_exp[h].pop_front() : obs_t'('0);
    endtask

    task automatic cyc(input logic st, input logic ab, input logic [7:0] d, input logic [7:0] m);
        start = st;
        abort = ab;
        data  = d;
        mask  = m;
        @(negedge clk);
        compare_all("cyc");
        @(posedge clk);
        if (rst) model_clear();
        else for (int h = 0; h < 3; h++) model_step(h);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        start = 1'b0;
        abort = 1'b0;
        data  = 8'd0;
        mask  = 8'd0;
        rst   = 1'b1;
        model_clear();
        cyc(1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        idle(2);

        // Full mask, alternating-ish data.
        cyc(1'b1, 1'b0, 8'hA5, 8'hFF);
        idle(28);
        // Sparse mask.
        cyc(1'b1, 1'b0, 8'h0F, 8'b1001_0010);
        idle(12);
        // Empty mask: done only.
        cyc(1'b1, 1'b0, 8'h3C, 8'h00);
        idle(3);
        // START held high with changing DATA/MASK: restarts only at IDLE.
        cyc(1'b1, 1'b0, 8'h5A, 8'b0110_0001);
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        idle(28);

        // Abort sampled while the HOLD=2 instance drives SEL=3.
        cyc(1'b1, 1'b0, 8'hC3, 8'hFF);
        idle(6);
        cyc(1'b0, 1'b1, 8'h00, 8'h00);
        idle(2);
        cyc(1'b1, 1'b0, 8'h96, 8'hFF);
        idle(28);

        // Async reset mid-transfer, between clock edges.
        cyc(1'b1, 1'b0, 8'hE7, 8'hFF);
        idle(5);
        #2 rst = 1'b1;
        #1;
        model_clear();
        compare_all("async_rst");
        cyc(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        idle(6);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_clear();
            end else begin
                rst = 1'b0;
            end
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 8'($urandom),
                ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
        end
        rst = 1'b0;
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
